// File: rtl/pclk_gen.sv
// pclk_gen: symbol clock, ratio-selectable PCLK and serializer strobe from one fast bit clock.
// Outputs are flopped from next-state counter values so they move on the same edge as the state.
`timescale 1ps/1ps
module pclk_gen #(
  parameter int SYM_BITS = 10
) (
  input  logic       Bit_Rate,
  input  logic       Rst,
  input  logic       En,
  input  logic [1:0] Width_Sel,
  output logic       Bit_Rate_10,
  output logic       PCLK,
  output logic       Sym_Strobe,
  output logic       Pclk_Rdy
);
  localparam int CW = $clog2(SYM_BITS);
  localparam logic [CW-1:0] LAST = CW'(SYM_BITS - 1);
  localparam logic [CW-1:0] HALF = CW'(SYM_BITS / 2);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state, state_n, active_sel, act_n, sym_cnt, sym_n, sel;
  logic [CW-1:0] bit_cnt, bit_n;
  logic wrap, bound, load, run_n, pclk_n, rdy_n;
  always_comb begin
    sel = Width_Sel == 2'b11 ? 2'b00 : Width_Sel;
    wrap = bit_cnt == LAST;
    bound = wrap && (active_sel == 2'b01 || (active_sel == 2'b10 ? sym_cnt == 2'd3 : sym_cnt[0]));
    load = bound && En && sel != active_sel;
    state_n = state == IDLE ? (En ? RUN : IDLE) : En ? RUN : bound ? IDLE : DRAIN;
    run_n = state_n != IDLE;
    act_n = (state == IDLE && En) || load ? sel : active_sel;
    bit_n = (state == IDLE || !run_n || wrap) ? '0 : bit_cnt + 1'b1;
    // A ratio load restarts the symbol count so the new period begins with its high phase
    sym_n = (state == IDLE || !run_n || load) ? 2'd0 : sym_cnt + {1'b0, wrap};
    pclk_n = act_n == 2'b01 ? bit_n < HALF : act_n == 2'b10 ? sym_n < 2'd2 : !sym_n[0];
    rdy_n = state_n == RUN && sel == active_sel && (Pclk_Rdy || (state != IDLE && bound));
  end
  always_ff @(posedge Bit_Rate or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      active_sel <= 2'b00;
      sym_cnt <= 2'd0;
      bit_cnt <= '0;
      Bit_Rate_10 <= 1'b0;
      PCLK <= 1'b0;
      Sym_Strobe <= 1'b0;
      Pclk_Rdy <= 1'b0;
    end else begin
      state <= state_n;
      active_sel <= act_n;
      sym_cnt <= sym_n;
      bit_cnt <= bit_n;
      Bit_Rate_10 <= run_n && bit_n < HALF;
      PCLK <= run_n && pclk_n;
      Sym_Strobe <= run_n && bit_n == LAST;
      Pclk_Rdy <= rdy_n;
    end
endmodule

// File: tb/tb_pclk_gen.sv
// tb_pclk_gen: phase-based reference model compared every cycle, plus hand-computed waveform pins.
`timescale 1ps/1ps
module tb_pclk_gen;
  localparam int SYM = 10;
  logic clk = 1'b0, Rst = 1'b0, En = 1'b0;
  logic [1:0] Width_Sel = 2'b00;
  logic Bit_Rate_10, PCLK, Sym_Strobe, Pclk_Rdy;
  int checks = 0, errors = 0, k = 0;
  bit m_run = 0, m_rdy = 0, fin;
  int m_ph = 0;
  logic [1:0] m_sel = 2'b00;

  pclk_gen #(.SYM_BITS(SYM)) dut (
    .Bit_Rate(clk), .Rst(Rst), .En(En), .Width_Sel(Width_Sel),
    .Bit_Rate_10(Bit_Rate_10), .PCLK(PCLK), .Sym_Strobe(Sym_Strobe), .Pclk_Rdy(Pclk_Rdy)
  );

  always #100 clk = ~clk;

  function automatic logic [1:0] nrm(input logic [1:0] w);
    return w == 2'b11 ? 2'b00 : w;
  endfunction

  function automatic int per(input logic [1:0] s);
    return s == 2'b01 ? SYM : s == 2'b10 ? 4 * SYM : 2 * SYM;
  endfunction

  task automatic check(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", n, $time, a, e);
    end
  endtask

  // Model tracks the phase within the current PCLK period rather than separate counters
  initial forever begin
    @(posedge clk);
    if (!Rst) begin
      m_run = 0;
      m_rdy = 0;
    end else if (!m_run) begin
      if (En) begin
        m_run = 1;
        m_ph = 0;
        m_sel = nrm(Width_Sel);
        m_rdy = 0;
      end
    end else begin
      fin = m_ph == per(m_sel) - 1;
      if (En) begin
        if (fin) begin
          if (nrm(Width_Sel) != m_sel) begin
            m_sel = nrm(Width_Sel);
            m_rdy = 0;
          end else m_rdy = 1;
          m_ph = 0;
        end else begin
          m_ph++;
          if (nrm(Width_Sel) != m_sel) m_rdy = 0;
        end
      end else if (fin) begin
        m_run = 0;
        m_rdy = 0;
      end else begin
        m_ph++;
        m_rdy = 0;
      end
    end
    #1;
    check("model br10", Bit_Rate_10, m_run && (m_ph % SYM) < SYM / 2);
    check("model pclk", PCLK, m_run && m_ph < per(m_sel) / 2);
    check("model strobe", Sym_Strobe, m_run && (m_ph % SYM) == SYM - 1);
    check("model rdy", Pclk_Rdy, m_rdy);
  end

  task automatic go(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic start();
    En = 1'b1;
    @(negedge clk);
    k = 0;
  endtask

  task automatic all_zero(input string n);
    check({n, " br10"}, Bit_Rate_10, 1'b0);
    check({n, " pclk"}, PCLK, 1'b0);
    check({n, " strobe"}, Sym_Strobe, 1'b0);
    check({n, " rdy"}, Pclk_Rdy, 1'b0);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk);
    all_zero("reset");
    Rst = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("idle after reset");
    start();
    check("start pclk", PCLK, 1'b1);
    check("start br10", Bit_Rate_10, 1'b1);
    check("start rdy", Pclk_Rdy, 1'b0);
    go(8);  check("strobe k8", Sym_Strobe, 1'b0);
    go(9);  check("strobe k9", Sym_Strobe, 1'b1); check("div20 pclk k9", PCLK, 1'b1);
    go(10); check("div20 pclk k10", PCLK, 1'b0);
    go(19); check("rdy k19", Pclk_Rdy, 1'b0);
    go(20); check("rdy k20", Pclk_Rdy, 1'b1); check("div20 pclk k20", PCLK, 1'b1);
    go(25); Width_Sel = 2'b10;
    go(26); check("rdy clear", Pclk_Rdy, 1'b0);
    go(29); check("old high k29", PCLK, 1'b1);
    go(30); check("old low k30", PCLK, 1'b0);
    go(39); check("old low k39", PCLK, 1'b0);
    go(40); check("div40 rise", PCLK, 1'b1);
    go(59); check("div40 high k59", PCLK, 1'b1);
    go(60); check("div40 low k60", PCLK, 1'b0);
    go(79); check("div40 rdy k79", Pclk_Rdy, 1'b0);
    go(80); check("div40 rdy k80", Pclk_Rdy, 1'b1);
    go(85); En = 1'b0;
    go(99); check("drain high k99", PCLK, 1'b1);
    go(100); check("drain low k100", PCLK, 1'b0); check("drain rdy", Pclk_Rdy, 1'b0);
    go(119); check("drain strobe k119", Sym_Strobe, 1'b1);
    go(120); all_zero("drained idle");
    start();
    go(5);  En = 1'b0;
    go(15); En = 1'b1;
    go(19); check("redrain high k19", PCLK, 1'b1);
    go(20); check("redrain low k20", PCLK, 1'b0);
    go(40); check("redrain rise k40", PCLK, 1'b1); check("redrain rdy k40", Pclk_Rdy, 1'b1);
    go(45);
    #30 Rst = 1'b0;
    En = 1'b0;
    #1 all_zero("async reset");
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    Width_Sel = 2'b11;
    repeat (2) @(negedge clk);
    all_zero("post reset idle");
    start();
    check("sel11 pclk k0", PCLK, 1'b1);
    go(9);  check("sel11 pclk k9", PCLK, 1'b1);
    go(10); check("sel11 pclk k10", PCLK, 1'b0);
    go(20); check("sel11 pclk k20", PCLK, 1'b1); check("sel11 rdy k20", Pclk_Rdy, 1'b1);
    go(25); Width_Sel = 2'b01;
    go(44); check("div10 pclk k44", PCLK, 1'b1);
    go(45); check("div10 pclk k45", PCLK, 1'b0);
    go(49); check("div10 strobe k49", Sym_Strobe, 1'b1); check("div10 rdy k49", Pclk_Rdy, 1'b0);
    go(50); check("div10 pclk k50", PCLK, Bit_Rate_10); check("div10 rdy k50", Pclk_Rdy, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 999);
      if (r < 20) En = ~En;
      else if (r < 50) Width_Sel = 2'($urandom_range(0, 3));
      else if (r < 53) begin
        #($urandom_range(1, 90)) Rst = 1'b0;
        #1 all_zero("random async reset");
        @(negedge clk);
        @(negedge clk);
        Rst = 1'b1;
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
